// File: rtl/imem_load_ctrl_if.sv
// Bundles the loader word stream, the CPU store port and the instruction-memory write port.
// The master drives ld_* and cpu_* requests; the slave (imem_load_ctrl) drives cpu_gnt and mem_*.
`timescale 1ns/1ps
interface imem_load_ctrl_if;
    logic [12:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_write;
    logic        cpu_req;
    logic [12:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;

    modport master (
        output ld_addr, ld_data, ld_write, cpu_req, cpu_addr, cpu_wdata,
        input  cpu_gnt, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  ld_addr, ld_data, ld_write, cpu_req, cpu_addr, cpu_wdata,
        output cpu_gnt, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory write-port owner: UART reprogram sessions hold the CPU in reset, else CPU stores.
// Latency: mem_* and cpu_gnt are registered, one cycle after the sampled word/request.
// Backpressure: loader never stalls (absolute priority); cpu_req waits, held until cpu_gnt. LOAD_PROTECT_EN drops writes >= PROT_BASE.
`timescale 1ns/1ps
module imem_load_ctrl #(
    parameter logic [12:0] INIT_ADDR   = 13'h1fff,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned RST_HOLD    = 16,
    parameter logic [12:0] PROT_BASE   = 13'h1f00
) (
    input  logic                 clk_50mhz,
    input  logic                 rstn,
    imem_load_ctrl_if.slave      bus,
    output logic                 cpu_rstn,
    output logic                 busy,
    output logic [13:0]          word_cnt,
    output logic                 err
);

    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

`ifdef LOAD_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [12:0]         last_addr_q;
    logic [13:0]         cnt_d, cnt_inc;
    logic                nw, prot_hit;
    logic                wr_en, gnt_d;
    logic [12:0]         wr_addr;
    logic [31:0]         wr_data;

    assign nw       = bus.ld_write && (bus.ld_addr != last_addr_q);
    assign prot_hit = PROT_EN && (bus.ld_addr >= PROT_BASE);
    assign cnt_inc  = (word_cnt == 14'h3fff) ? word_cnt : word_cnt + 14'd1;

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        hold_d  = hold_q;
        cnt_d   = word_cnt;
        wr_en   = 1'b0;
        gnt_d   = 1'b0;
        wr_addr = bus.ld_addr;
        wr_data = bus.ld_data;
        case (state_q)
            S_IDLE: begin
                if (nw) begin
                    state_d = S_LOAD;
                    to_d    = '0;
                    wr_en   = !prot_hit;
                    cnt_d   = 14'd1;
                end else if (bus.cpu_req && !bus.cpu_gnt) begin
                    // The gnt guard stops a still-held request from being granted twice.
                    gnt_d   = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = bus.cpu_addr;
                    wr_data = bus.cpu_wdata;
                end
            end
            S_LOAD: begin
                if (nw) begin
                    to_d  = '0;
                    wr_en = !prot_hit;
                    cnt_d = cnt_inc;
                end else if (to_q == TO_LAST) begin
                    state_d = S_RELEASE;
                    hold_d  = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (nw) begin
                    // Late word resumes the same session, so the count keeps running.
                    state_d = S_LOAD;
                    hold_d  = '0;
                    to_d    = '0;
                    wr_en   = !prot_hit;
                    cnt_d   = cnt_inc;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_RELEASE;
            to_q          <= '0;
            hold_q        <= '0;
            last_addr_q   <= INIT_ADDR;
            word_cnt      <= '0;
            cpu_rstn      <= 1'b0;
            busy          <= 1'b0;
            bus.cpu_gnt   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state_q     <= state_d;
            to_q        <= to_d;
            hold_q      <= hold_d;
            word_cnt    <= cnt_d;
            cpu_rstn    <= (state_d == S_IDLE);
            busy        <= (state_d != S_IDLE);
            bus.cpu_gnt <= gnt_d;
            bus.mem_we  <= wr_en;
            if (nw) begin
                last_addr_q <= bus.ld_addr;
            end
            if (wr_en) begin
                bus.mem_addr  <= wr_addr;
                bus.mem_wdata <= wr_data;
            end
        end
    end

`ifdef LOAD_PROTECT_EN
    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (nw && prot_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized scoreboard bench for imem_load_ctrl (TIMEOUT_CYC=1000, RST_HOLD=16).
`timescale 1ns/1ps
module tb_imem_load_ctrl;
    localparam int TO   = 1000;
    localparam int HOLD = 16;
`ifdef LOAD_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    logic        clk_50mhz = 1'b0;
    logic        rstn = 1'b1;
    logic        cpu_rstn, busy, err;
    logic [13:0] word_cnt;

    imem_load_ctrl_if bus ();

    imem_load_ctrl #(.TIMEOUT_CYC(TO), .RST_HOLD(HOLD)) dut (
        .clk_50mhz (clk_50mhz),
        .rstn      (rstn),
        .bus       (bus),
        .cpu_rstn  (cpu_rstn),
        .busy      (busy),
        .word_cnt  (word_cnt),
        .err       (err)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
        logic        is_cpu;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_cnt = 0;
    bit  in_session = 1'b0;
    bit  exp_err = 1'b0;
    logic [12:0] cur_addr = 13'h1fff;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge clk_50mhz) begin : mon
        wr_t e;
        if (rstn) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h:%0h gnt=%0b required=none",
                             bus.mem_addr, bus.mem_wdata, bus.cpu_gnt);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_addr, e.addr);
                    check("wr_data", bus.mem_wdata, e.data);
                    check("wr_gnt", bus.cpu_gnt, e.is_cpu);
                end
            end else if (bus.cpu_gnt) begin
                check("gnt_without_we", bus.mem_we, 1'b1);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    // One assembled word; the model decides whether it is written and what word_cnt becomes.
    task automatic issue_word(input logic [12:0] a, input logic [31:0] d);
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_write = 1'b1;
        cur_addr     = a;
        if (PROT_ON && a >= 13'h1f00) exp_err = 1'b1;
        else exp_q.push_back({a, d, 1'b0});
        if (!in_session) begin
            exp_cnt    = 1;
            in_session = 1'b1;
        end else if (exp_cnt < 16383) begin
            exp_cnt++;
        end
    endtask

    // Called right after the last word of a session was driven, 'pre' cycles already spent.
    task automatic wait_session_end(input string tag, input int pre);
        int n = pre;
        int g = 0;
        while (cpu_rstn !== 1'b1 && n < 1300) begin
            tick();
            n++;
            if (bus.cpu_gnt) g++;
        end
        checks++;
        if (n < TO + HOLD || n > TO + HOLD + 1) begin
            errors++;
            $display("FAIL %s_session_len actual=%0d required=%0d..%0d", tag, n, TO + HOLD, TO + HOLD + 1);
        end
        check({tag, "_gnt_in_session"}, g, 0);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_word_cnt"}, word_cnt, exp_cnt);
        check({tag, "_err"}, err, exp_err);
        in_session = 1'b0;
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        while (bus.cpu_gnt !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_gnt_latency"}, n, 1);
        bus.cpu_req = 1'b0;
    endtask

    task automatic measure_release(input string tag);
        int n = 0;
        while (cpu_rstn !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, HOLD);
    endtask

    task automatic random_session(input string tag, input logic [12:0] first, input bit with_cpu);
        int nw = $urandom_range(4, 12);
        logic [12:0] a;
        logic [12:0] ca = 13'($urandom);
        logic [31:0] cd = $urandom;
        a = first;
        for (int i = 0; i < nw; i++) begin
            if (i > 0) begin
                tick($urandom_range(1, 40));
                a = a + 13'($urandom_range(1, 3));
            end
            issue_word(a, $urandom);
            if (i == 0 && with_cpu) begin
                bus.cpu_req   = 1'b1;
                bus.cpu_addr  = ca;
                bus.cpu_wdata = cd;
            end
        end
        if (with_cpu) exp_q.push_back({ca, cd, 1'b1});
        wait_session_end(tag, 0);
        if (with_cpu) wait_gnt(tag);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ld_addr   = 13'h1fff;
        bus.ld_data   = '0;
        bus.ld_write  = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        // Reset values
        #3 rstn = 1'b0;
        #12;
        check("rst_mem_addr", bus.mem_addr, 13'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
        check("rst_cpu_rstn", cpu_rstn, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_word_cnt", word_cnt, 14'h0);
        check("rst_err", err, 1'b0);
        tick();
        rstn = 1'b1;
        measure_release("s1_release_len");

        // INIT_ADDR with ld_write high is not a new word
        bus.ld_write = 1'b1;
        tick(5);
        check("s1_init_addr_busy", busy, 1'b0);
        check("s1_init_addr_rstn", cpu_rstn, 1'b1);

        // Wrap into 0000, then 0001
        issue_word(13'h0000, 32'hA5A5A5A5);
        tick();
        check("s2_cpu_rstn_low", cpu_rstn, 1'b0);
        check("s2_busy", busy, 1'b1);
        issue_word(13'h0001, 32'h12345678);
        tick();
        check("s2_word_cnt", word_cnt, 14'd2);
        wait_session_end("s2", 1);

        // Simultaneous loader word and CPU store: loader first, CPU after session
        issue_word(13'h0002, $urandom);
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 13'h0040;
        bus.cpu_wdata = 32'hDEADBEEF;
        exp_q.push_back({13'h0040, 32'hDEADBEEF, 1'b1});
        tick();
        check("s3_no_gnt_on_nw", bus.cpu_gnt, 1'b0);
        check("s3_loader_we", bus.mem_we, 1'b1);
        wait_session_end("s3", 1);
        wait_gnt("s3");

        // Random CPU stores in IDLE
        for (int i = 0; i < 6; i++) begin
            tick($urandom_range(1, 3));
            bus.cpu_req   = 1'b1;
            bus.cpu_addr  = 13'($urandom);
            bus.cpu_wdata = $urandom;
            exp_q.push_back({bus.cpu_addr, bus.cpu_wdata, 1'b1});
            wait_gnt("cpu_rand");
        end

        // Words 999 cycles apart never time out
        tick(2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick(999);
                check("s4_rstn_held", cpu_rstn, 1'b0);
                check("s4_busy_held", busy, 1'b1);
            end
            issue_word(cur_addr + 13'd1, $urandom);
        end
        tick(2);
        check("s4_word_cnt", word_cnt, 14'd5);
        // A word arriving during the release hold resumes the session without clearing the count
        tick(1005);
        check("s4_rel_busy", busy, 1'b1);
        check("s4_rel_rstn", cpu_rstn, 1'b0);
        issue_word(cur_addr + 13'd1, $urandom);
        wait_session_end("s4_reentry", 0);

        // Randomized sessions, including a wrap through 1fff->0000
        random_session("rs0", cur_addr + 13'd1, 1'b1);
        random_session("rs1", cur_addr + 13'd7, 1'b0);
        random_session("rs_wrap", 13'h1ffe, 1'b1);
        random_session("rs2", cur_addr + 13'd2, 1'b1);

        // Reset mid-session after 3 words
        tick(3);
        for (int i = 0; i < 3; i++) begin
            issue_word(cur_addr + 13'd1, $urandom);
            tick(2);
        end
        tick(2);
        check("s5_queue_drained", exp_q.size(), 0);
        bus.ld_addr = cur_addr + 13'd1;
        bus.ld_data = $urandom;
        rstn = 1'b0;
        #1;
        check("s5_mem_we", bus.mem_we, 1'b0);
        check("s5_word_cnt", word_cnt, 14'h0);
        check("s5_cpu_rstn", cpu_rstn, 1'b0);
        check("s5_busy", busy, 1'b0);
        in_session = 1'b0;
        exp_cnt    = 0;
        exp_err    = 1'b0;
        tick(2);
        check("s5_mem_we_held", bus.mem_we, 1'b0);
        bus.ld_addr  = 13'h1fff;
        bus.ld_write = 1'b0;
        cur_addr     = 13'h1fff;
        rstn = 1'b1;
        measure_release("s5_release_len");

        // Protected boundary: 1eff then 1f00
        check("s6_err_before", err, 1'b0);
        issue_word(13'h1eff, 32'h0BADF00D);
        tick(3);
        issue_word(13'h1f00, 32'hC0FFEE00);
        wait_session_end("s6", 0);

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
